mmu_trans_arb: RTL and testbench

- Shares the single combinational address-translation port (DMW/TLB lookup, `addr_trans`) between three requesters: instruction fetch (IF), load/store unit (LSU) and CSR probe (CSR).
- Grants at most one requester per cycle and drives its VA onto the port.
- Registers the translation result and returns it to the granted requester one cycle later.
- Sits in the MMU between the pipeline front/back ends and `addr_trans`.

---
 rtl/mmu_trans_arb_pkg.sv | 45 ++++
 rtl/mmu_trans_arb_if.sv | 28 ++
 rtl/mmu_trans_arb_prio_sel.sv | 27 ++
 rtl/mmu_trans_arb.sv | 104 ++++++++++
 tb/tb_mmu_trans_arb.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/mmu_trans_arb_pkg.sv
// Shared types for the address-translation arbiter: result bundle, owner id
// and requester slot helpers.
package mmu_trans_arb_pkg;

    typedef struct packed {
        logic [31:0] pa;
        logic [1:0]  mat;
        logic        page_fault;
        logic        page_invalid;
        logic        page_dirty;
        logic        plv_fault;
    } trans_rsp_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LSU  = 2'd2,
        OWN_CSR  = 2'd3
    } trans_owner_e;

    // Bit positions of each requester in the grant / valid vectors.
    localparam int SLOT_IF  = 0;
    localparam int SLOT_LSU = 1;
    localparam int SLOT_CSR = 2;
    localparam int NUM_SLOTS = 3;

    function automatic trans_owner_e slot_owner(input int slot);
        case (slot)
            SLOT_IF:  return OWN_IF;
            SLOT_LSU: return OWN_LSU;
            SLOT_CSR: return OWN_CSR;
            default:  return OWN_NONE;
        endcase
    endfunction

    function automatic trans_owner_e grant_to_owner(input logic [2:0] gnt);
        trans_owner_e owner;
        owner = OWN_NONE;
        if (gnt[SLOT_IF])  owner = OWN_IF;
        if (gnt[SLOT_LSU]) owner = OWN_LSU;
        if (gnt[SLOT_CSR]) owner = OWN_CSR;
        return owner;
    endfunction

endpackage

// File: rtl/mmu_trans_arb_if.sv
// One requester's view of the translation arbiter: request handshake plus
// the one-cycle-later result.
interface mmu_trans_arb_if;
    import mmu_trans_arb_pkg::*;

    logic        req_valid;
    logic [31:0] req_va;
    logic        req_ready;
    logic        rsp_valid;
    trans_rsp_t  rsp;

    modport master (
        output req_valid,
        output req_va,
        input  req_ready,
        input  rsp_valid,
        input  rsp
    );

    modport slave (
        input  req_valid,
        input  req_va,
        output req_ready,
        output rsp_valid,
        output rsp
    );

endinterface

// File: rtl/mmu_trans_arb_prio_sel.sv
// Combinational priority picker: CSR > starved IF > LSU > IF, with flush
// blocking IF and LSU.
module trans_prio_sel
    import mmu_trans_arb_pkg::*;
(
    input  logic [2:0] req_valid,
    input  logic       if_starved,
    input  logic       flush,
    output logic [2:0] gnt
);

    always_comb begin
        gnt = '0;
        if (req_valid[SLOT_CSR]) begin
            gnt[SLOT_CSR] = 1'b1;
        end else if (!flush) begin
            if (req_valid[SLOT_IF] && if_starved) begin
                gnt[SLOT_IF] = 1'b1;
            end else if (req_valid[SLOT_LSU]) begin
                gnt[SLOT_LSU] = 1'b1;
            end else if (req_valid[SLOT_IF]) begin
                gnt[SLOT_IF] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmu_trans_arb.sv
// Shares the combinational addr_trans port between IF, LSU and CSR probe;
// the result comes back through a shared register one cycle after the grant.
module mmu_trans_arb
    import mmu_trans_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    mmu_trans_arb_if.slave ifu,
    mmu_trans_arb_if.slave lsu,
    mmu_trans_arb_if.slave csr,
    output logic [31:0] at_va,
    input  logic [31:0] at_pa,
    input  logic [1:0]  at_mat,
    input  logic        at_page_fault,
    input  logic        at_page_invalid,
    input  logic        at_page_dirty,
    input  logic        at_plv_fault
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [2:0]   req_valid;
    logic [2:0]   gnt;
    logic [2:0]   rsp_valid;
    logic         if_starved;
    trans_rsp_t   at_rsp;
    trans_rsp_t   rsp_out;
    trans_owner_e owner_reg, owner_next;
    trans_rsp_t   result_reg;
    logic [3:0]   starve_cnt_reg, starve_cnt_next;

    // Masking valids with reset keeps every ready low while reset is held.
    assign req_valid = {csr.req_valid, lsu.req_valid, ifu.req_valid} & {3{~reset}};
    assign if_starved = (starve_cnt_reg == STARVE_LIM);

    trans_prio_sel u_prio_sel (
        .req_valid (req_valid),
        .if_starved(if_starved),
        .flush     (flush),
        .gnt       (gnt)
    );

    // IF VA is the idle default so the TLB index is already driven for fetch.
    always_comb begin
        at_va = ifu.req_va;
        if (gnt[SLOT_LSU]) at_va = lsu.req_va;
        if (gnt[SLOT_CSR]) at_va = csr.req_va;
    end

    assign at_rsp = '{
        pa:           at_pa,
        mat:          at_mat,
        page_fault:   at_page_fault,
        page_invalid: at_page_invalid,
        page_dirty:   at_page_dirty,
        plv_fault:    at_plv_fault
    };

    assign owner_next = grant_to_owner(gnt);

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (flush || !ifu.req_valid || gnt[SLOT_IF]) begin
            starve_cnt_next = '0;
        end else if (starve_cnt_reg != STARVE_LIM) begin
            starve_cnt_next = starve_cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_reg      <= OWN_NONE;
            result_reg     <= '0;
            starve_cnt_reg <= '0;
        end else begin
            owner_reg      <= owner_next;
            starve_cnt_reg <= starve_cnt_next;
            if (|gnt) result_reg <= at_rsp;
        end
    end

    // A response still pending when reset rises is dropped, not presented.
    assign rsp_out = reset ? '0 : result_reg;

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_rsp_valid
        assign rsp_valid[gi] = !reset && (owner_reg == slot_owner(gi));
    end

    assign ifu.req_ready = gnt[SLOT_IF];
    assign lsu.req_ready = gnt[SLOT_LSU];
    assign csr.req_ready = gnt[SLOT_CSR];

    assign ifu.rsp_valid = rsp_valid[SLOT_IF];
    assign lsu.rsp_valid = rsp_valid[SLOT_LSU];
    assign csr.rsp_valid = rsp_valid[SLOT_CSR];

    assign ifu.rsp = rsp_out;
    assign lsu.rsp = rsp_out;
    assign csr.rsp = rsp_out;

endmodule

// File: tb/tb_mmu_trans_arb.sv
// Scoreboard bench for mmu_trans_arb: each cycle checks grants/at_va and
// queues the expected response, which is checked the following cycle.
module tb_mmu_trans_arb;
    import mmu_trans_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] at_va;
    logic [31:0] at_pa;
    logic [1:0]  at_mat;
    logic        at_page_fault, at_page_invalid, at_page_dirty, at_plv_fault;

    mmu_trans_arb_if ifu ();
    mmu_trans_arb_if lsu ();
    mmu_trans_arb_if csr ();

    // Translation stub: PA is a fixed XOR of the VA on the port.
    assign at_pa = at_va ^ 32'h1C00_0000;

    mmu_trans_arb #(.STARVE_MAX(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .ifu            (ifu),
        .lsu            (lsu),
        .csr            (csr),
        .at_va          (at_va),
        .at_pa          (at_pa),
        .at_mat         (at_mat),
        .at_page_fault  (at_page_fault),
        .at_page_invalid(at_page_invalid),
        .at_page_dirty  (at_page_dirty),
        .at_plv_fault   (at_plv_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        trans_owner_e owner;
        trans_rsp_t   rsp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic set_req(input logic iv, input logic [31:0] iva,
                           input logic lv, input logic [31:0] lva,
                           input logic cv, input logic [31:0] cva);
        ifu.req_valid = iv; ifu.req_va = iva;
        lsu.req_valid = lv; lsu.req_va = lva;
        csr.req_valid = cv; csr.req_va = cva;
    endtask

    // One clock cycle: check last cycle's response, this cycle's grant, queue the next response.
    task automatic step(input trans_owner_e exp_gnt, input string tag);
        exp_t        e;
        exp_t        nxt;
        logic [2:0]  exp_vld, act_vld, exp_rdy, act_rdy;
        logic [31:0] exp_va;
        trans_rsp_t  act_rsp [3];
        @(negedge clk);
        if (sb.size() > 0) e = sb.pop_front();
        else begin e.owner = OWN_NONE; e.rsp = '0; end
        if (reset) begin e.owner = OWN_NONE; e.rsp = '0; end
        exp_vld = {e.owner == OWN_CSR, e.owner == OWN_LSU, e.owner == OWN_IF};
        act_vld = {csr.rsp_valid, lsu.rsp_valid, ifu.rsp_valid};
        checks++;
        if (act_vld !== exp_vld) begin
            errors++;
            $display("FAIL %s rsp_valid{csr,lsu,if}: got %b want %b", tag, act_vld, exp_vld);
        end
        act_rsp[0] = ifu.rsp; act_rsp[1] = lsu.rsp; act_rsp[2] = csr.rsp;
        for (int k = 0; k < 3; k++) begin
            if (exp_vld[k] || reset) begin
                checks++;
                if (act_rsp[k] !== e.rsp) begin
                    errors++;
                    $display("FAIL %s rsp[%0d]: got %h want %h", tag, k, act_rsp[k], e.rsp);
                end
            end
        end
        exp_rdy = {exp_gnt == OWN_CSR, exp_gnt == OWN_LSU, exp_gnt == OWN_IF};
        act_rdy = {csr.req_ready, lsu.req_ready, ifu.req_ready};
        checks++;
        if (act_rdy !== exp_rdy) begin
            errors++;
            $display("FAIL %s req_ready{csr,lsu,if}: got %b want %b", tag, act_rdy, exp_rdy);
        end
        case (exp_gnt)
            OWN_LSU: exp_va = lsu.req_va;
            OWN_CSR: exp_va = csr.req_va;
            default: exp_va = ifu.req_va;
        endcase
        checks++;
        if (at_va !== exp_va) begin
            errors++;
            $display("FAIL %s at_va: got %h want %h", tag, at_va, exp_va);
        end
        nxt.owner = exp_gnt;
        nxt.rsp   = '{pa: exp_va ^ 32'h1C00_0000, mat: at_mat, page_fault: at_page_fault,
                      page_invalid: at_page_invalid, page_dirty: at_page_dirty,
                      plv_fault: at_plv_fault};
        sb.push_back(nxt);
        $display("[%0t] %s grant=%s rsp_owner=%s at_va=%h", $time, tag, exp_gnt.name(),
                 e.owner.name(), at_va);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_req(1'b1, 32'h1C00_0100, 1'b1, 32'h8000_0000, 1'b1, 32'h9000_0000);
        step(OWN_NONE, "reset_hold");
        step(OWN_NONE, "reset_hold");
        reset = 1'b0;
        set_req(1'b0, 32'h1234_5670, 1'b0, 32'h8000_0000, 1'b0, 32'h9000_0000);
        step(OWN_NONE, "reset_idle");
        step(OWN_NONE, "reset_idle");
    endtask

    task automatic test_if_only();
        at_mat = 2'd1;
        set_req(1'b1, 32'h1C00_0000, 1'b0, 32'h0, 1'b0, 32'h0);
        step(OWN_IF, "if_only");
        set_req(1'b0, 32'h1C00_0040, 1'b0, 32'h0, 1'b0, 32'h0);
        at_mat = 2'd0;
        step(OWN_NONE, "if_only_rsp");
    endtask

    task automatic test_starve();
        at_mat = 2'd2;
        set_req(1'b1, 32'h1C00_1000, 1'b1, 32'h8000_2000, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            step((i % 5 == 4) ? OWN_IF : OWN_LSU, "starve");
        end
        set_req(1'b0, 32'h1C00_1000, 1'b0, 32'h0, 1'b0, 32'h0);
        at_mat = 2'd0;
        step(OWN_NONE, "starve_drain");
    endtask

    task automatic test_csr_starved();
        set_req(1'b1, 32'h1C00_2000, 1'b1, 32'h8000_3000, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) step(OWN_LSU, "csr_prep");
        csr.req_valid = 1'b1; csr.req_va = 32'h9000_0040;
        at_plv_fault = 1'b1;
        step(OWN_CSR, "csr_win");
        csr.req_valid = 1'b0;
        at_plv_fault = 1'b0;
        step(OWN_IF, "csr_then_if");
        step(OWN_LSU, "csr_then_lsu");
        set_req(1'b0, 32'h1C00_2000, 1'b0, 32'h0, 1'b0, 32'h0);
        step(OWN_NONE, "csr_drain");
    endtask

    task automatic test_flush();
        at_page_dirty = 1'b1;
        set_req(1'b1, 32'h1C00_3000, 1'b1, 32'h8000_4000, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) step(OWN_LSU, "flush_prep");
        flush = 1'b1;
        csr.req_valid = 1'b1; csr.req_va = 32'h9000_0080;
        at_page_dirty = 1'b0;
        at_page_fault = 1'b1;
        step(OWN_CSR, "flush_csr");
        flush = 1'b0;
        csr.req_valid = 1'b0;
        at_page_fault = 1'b0;
        for (int i = 0; i < 5; i++) step((i == 4) ? OWN_IF : OWN_LSU, "flush_after");
        set_req(1'b0, 32'h1C00_3000, 1'b0, 32'h0, 1'b0, 32'h0);
        step(OWN_NONE, "flush_drain");
    endtask

    task automatic test_reset_mid();
        at_page_invalid = 1'b1;
        set_req(1'b1, 32'h1C00_4000, 1'b1, 32'h8000_5000, 1'b0, 32'h0);
        step(OWN_LSU, "rst_mid_grant");
        reset = 1'b1;
        step(OWN_NONE, "rst_mid_hold");
        reset = 1'b0;
        at_page_invalid = 1'b0;
        step(OWN_LSU, "rst_mid_restart");
        step(OWN_LSU, "rst_mid_restart");
        set_req(1'b0, 32'h1C00_4000, 1'b0, 32'h0, 1'b0, 32'h0);
        step(OWN_NONE, "rst_mid_drain");
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        at_mat = 2'd0;
        at_page_fault = 1'b0;
        at_page_invalid = 1'b0;
        at_page_dirty = 1'b0;
        at_plv_fault = 1'b0;
        set_req(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        test_reset();
        test_if_only();
        test_starve();
        test_csr_starved();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
